// File: rtl/y86_exec_alu.sv
// y86_exec_alu: registered execute-stage ALU for the multi-cycle Y86 CPU.
// Computes the selected operation on operands a (valA/valC/+-8) and b (valB),
// registers the result every cycle, loads CF/ZF/SF/OF when set_cc is high,
// and evaluates the jXX/cmovXX condition against the held flags.
module y86_exec_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             set_cc,
  input  logic [3:0]       cond_fn,
  output logic [WIDTH-1:0] alu_out,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cond_true
);

  localparam logic [3:0] SEL_ADD   = 4'd0;
  localparam logic [3:0] SEL_SUB   = 4'd1;
  localparam logic [3:0] SEL_AND   = 4'd2;
  localparam logic [3:0] SEL_XOR   = 4'd3;
  localparam logic [3:0] SEL_OR    = 4'd4;
  localparam logic [3:0] SEL_PASSA = 4'd5;
  localparam logic [3:0] SEL_PASSB = 4'd6;
  localparam logic [3:0] SEL_SHL   = 4'd7;
  localparam logic [3:0] SEL_SHR   = 4'd8;
  localparam logic [3:0] SEL_SAR   = 4'd9;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  // Intermediate results of the current operation (before flag gating).
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [5:0]       shamt;
  logic [WIDTH-1:0] r;
  logic             r_cf;
  logic             r_of;

  // Result and raw flags for the selected operation; flags gated by set_cc.
  always_comb begin
    add_full = {1'b0, b} + {1'b0, a};
    sub_res  = b - a;
    shamt    = a[5:0];
    r        = '0;
    r_cf     = 1'b0;
    r_of     = 1'b0;
    case (alu_sel)
      SEL_ADD: begin
        r    = add_full[WIDTH-1:0];
        r_cf = add_full[WIDTH];
        // Same-sign operands producing an opposite-sign sum.
        r_of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
      end
      SEL_SUB: begin
        r    = sub_res;
        r_cf = (b < a);
        // Differing-sign operands where the result sign departs from b.
        r_of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
      end
      SEL_AND:   r = b & a;
      SEL_XOR:   r = b ^ a;
      SEL_OR:    r = b | a;
      SEL_PASSA: r = a;
      SEL_PASSB: r = b;
      SEL_SHL:   r = b << shamt;
      SEL_SHR:   r = b >> shamt;
      SEL_SAR:   r = $unsigned($signed(b) >>> shamt);
      default:   r = '0;
    endcase

    alu_out_d = r;
    cf_d      = cf_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    if (set_cc) begin
      cf_d = r_cf;
      zf_d = (r == '0);
      sf_d = r[WIDTH-1];
      of_d = r_of;
    end
  end

  // Result loads every edge; flags follow the gated next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      cf_q      <= cf_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  // Y86 branch/cmov condition from the held flags (cf is not consulted).
  always_comb begin
    cond_true = 1'b0;
    case (cond_fn)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = (sf_q ^ of_q) | zf_q;
      4'd2:    cond_true = sf_q ^ of_q;
      4'd3:    cond_true = zf_q;
      4'd4:    cond_true = ~zf_q;
      4'd5:    cond_true = ~(sf_q ^ of_q);
      4'd6:    cond_true = ~(sf_q ^ of_q) & ~zf_q;
      default: cond_true = 1'b0;
    endcase
  end

  assign alu_out = alu_out_q;
  assign cf      = cf_q;
  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;

endmodule

// File: tb/tb_y86_exec_alu.sv
// tb_y86_exec_alu: directed vectors with hand-computed results for the
// registered Y86 execute ALU, including flag hold and asynchronous reset.
`timescale 1ns/1ps
module tb_y86_exec_alu;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_sel;
  logic         set_cc;
  logic [3:0]   cond_fn;
  logic [W-1:0] alu_out;
  logic         cf, zf, sf, of;
  logic         cond_true;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  y86_exec_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .set_cc    (set_cc),
    .cond_fn   (cond_fn),
    .alu_out   (alu_out),
    .cf        (cf),
    .zf        (zf),
    .sf        (sf),
    .of        (of),
    .cond_true (cond_true)
  );

  // Clock: 20 ns period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample 1 ns after the
  // rising edge and check alu_out against the scoreboard.
  task automatic drive_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [3:0] sel, input logic cc,
                          input logic [W-1:0] exp_out, input string tag);
    @(negedge clk);
    a = va; b = vb; alu_sel = sel; set_cc = cc;
    exp_q.push_back(exp_out);
    @(posedge clk);
    #1;
    check_eq({tag, "_out"}, alu_out, exp_q.pop_front());
  endtask

  task automatic check_flags(input string tag, input logic ecf,
                             input logic ezf, input logic esf, input logic eof);
    check_eq({tag, "_cf"}, {63'd0, cf}, {63'd0, ecf});
    check_eq({tag, "_zf"}, {63'd0, zf}, {63'd0, ezf});
    check_eq({tag, "_sf"}, {63'd0, sf}, {63'd0, esf});
    check_eq({tag, "_of"}, {63'd0, of}, {63'd0, eof});
  endtask

  task automatic check_cond(input string tag, input logic [3:0] fn,
                            input logic exp);
    cond_fn = fn;
    #1;
    check_eq(tag, {63'd0, cond_true}, {63'd0, exp});
  endtask

  initial begin
    // Reset block: hold reset with random inputs across several edges.
    rst_n = 1'b0; a = '0; b = '0; alu_sel = '0; set_cc = 1'b0; cond_fn = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      alu_sel = 4'($urandom_range(0, 15)); set_cc = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("rst_out", alu_out, '0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cond("rst_cond0", 4'd0, 1'b1);
    check_cond("rst_cond3", 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD signed overflow.
    drive_op(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, 1'b1,
             64'h8000_0000_0000_0000, "add_ovf");
    check_flags("add_ovf", 1'b0, 1'b0, 1'b1, 1'b1);
    check_cond("add_ovf_l", 4'd2, 1'b0);
    check_cond("add_ovf_le", 4'd1, 1'b0);

    // SUB equal.
    drive_op(64'd5, 64'd5, 4'd1, 1'b1, 64'd0, "sub_eq");
    check_flags("sub_eq", 1'b0, 1'b1, 1'b0, 1'b0);
    check_cond("sub_eq_e", 4'd3, 1'b1);
    check_cond("sub_eq_ne", 4'd4, 1'b0);

    // SUB borrow: 5 - 6.
    drive_op(64'd6, 64'd5, 4'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "sub_brw");
    check_flags("sub_brw", 1'b1, 1'b0, 1'b1, 1'b0);
    check_cond("sub_brw_l", 4'd2, 1'b1);
    check_cond("sub_brw_g", 4'd6, 1'b0);

    // Stack adjust with flags held.
    drive_op(64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 4'd0, 1'b0, 64'hF8, "rsp_adj");
    check_flags("rsp_adj", 1'b1, 1'b0, 1'b1, 1'b0);

    // XOR clears arithmetic flags.
    drive_op(64'hF0, 64'hFF, 4'd3, 1'b1, 64'h0F, "xor");
    check_flags("xor", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cond("xor_g", 4'd6, 1'b1);
    check_cond("xor_ge", 4'd5, 1'b1);

    // Arithmetic shift right of the sign bit.
    drive_op(64'd4, 64'h8000_0000_0000_0000, 4'd9, 1'b1,
             64'hF800_0000_0000_0000, "sar");
    check_flags("sar", 1'b0, 1'b0, 1'b1, 1'b0);

    // SUB signed overflow: min - 1.
    drive_op(64'd1, 64'h8000_0000_0000_0000, 4'd1, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, "sub_ovf");
    check_flags("sub_ovf", 1'b0, 1'b0, 1'b0, 1'b1);
    check_cond("sub_ovf_ge", 4'd5, 1'b0);
    check_cond("sub_ovf_le", 4'd1, 1'b1);
    check_cond("sub_ovf_c7", 4'd7, 1'b0);

    // ADD unsigned carry to zero.
    drive_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1, 64'd0, "add_cy");
    check_flags("add_cy", 1'b1, 1'b1, 1'b0, 1'b0);

    // Remaining operations; shifts use only a[5:0].
    drive_op(64'h41, 64'd3, 4'd7, 1'b0, 64'd6, "shl");
    drive_op(64'h40, 64'h1234, 4'd8, 1'b0, 64'h1234, "shr0");
    drive_op(64'd4, 64'h8000_0000_0000_0000, 4'd8, 1'b0,
             64'h0800_0000_0000_0000, "shr");
    drive_op(64'hF0F0, 64'hFF00, 4'd2, 1'b0, 64'hF000, "and");
    drive_op(64'hF0F0, 64'h0F00, 4'd4, 1'b0, 64'hFFF0, "or");
    drive_op(64'hAAAA, 64'h5555, 4'd5, 1'b0, 64'hAAAA, "passa");
    drive_op(64'hAAAA, 64'h5555, 4'd6, 1'b0, 64'h5555, "passb");
    check_flags("held", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_op(64'hAAAA, 64'h5555, 4'd12, 1'b1, 64'd0, "sel12");
    check_flags("sel12", 1'b0, 1'b1, 1'b0, 1'b0);

    // Async reset between edges after a nonzero result with flags set.
    drive_op(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, 1'b1,
             64'h8000_0000_0000_0000, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", alu_out, '0);
    check_flags("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    drive_op(64'd2, 64'd3, 4'd0, 1'b1, 64'd5, "post_rst");
    check_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Final report.
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_exec_alu.md
Name: y86_exec_alu

Overview:
- Registered 64-bit execute-stage ALU for the Y86-style multi-cycle CPU.
- Sits between the operand muxes (A = valA, valC or ±8; B = valB) and the data bus / memory-address mux.
- Computes the result selected by the controller and holds the condition codes CF/ZF/SF/OF.
- Evaluates the jXX/cmov condition against the held flags.

Parameters:
- WIDTH, 64, datapath width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  execute-phase clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A (valA, valC, +8 or -8 from the operand mux).
- b  input  WIDTH  operand B (valB).
- alu_sel  input  4  operation select, encoding in Behaviour.
- set_cc  input  1  when 1, flags load on this rising edge.
- cond_fn  input  4  Y86 condition function (ifun of jXX/cmovXX).
- alu_out  output  WIDTH  registered result.
- cf  output  1  registered carry/borrow flag.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered signed-overflow flag.
- cond_true  output  1  combinational condition result from the registered flags.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: alu_out=0, cf=0, zf=0, sf=0, of=0; applies immediately, independent of clk. Deassertion takes effect from the next rising edge.
- Latency: result of a/b/alu_sel sampled at rising edge N appears on alu_out after edge N, held until edge N+1. alu_out loads every edge regardless of set_cc.
- alu_sel encoding (r = next alu_out):
  - 0 ADD: r = b + a
  - 1 SUB: r = b - a (Y86 subq: rB - rA)
  - 2 AND: r = b & a
  - 3 XOR: r = b ^ a
  - 4 OR: r = b | a
  - 5 PASSA: r = a
  - 6 PASSB: r = b
  - 7 SHL: r = b << a[5:0]
  - 8 SHR: r = logical b >> a[5:0]
  - 9 SAR: r = arithmetic b >>> a[5:0]
  - 10-15: r = 0
- Flag computation:
  - zf = (r == 0); sf = r[WIDTH-1].
  - ADD: cf = unsigned carry-out of bit WIDTH-1; of = 1 when a and b have the same sign and r differs in sign.
  - SUB: cf = borrow (b < a unsigned); of = 1 when a and b differ in sign and r's sign differs from b's.
  - All other ops: cf=0, of=0.
- Flags load only when set_cc=1 at the edge; otherwise cf/zf/sf/of hold their previous values.
- cond_true, combinational from the registered flags (cf unused):
  - 0 always 1
  - 1 le: (sf^of)|zf
  - 2 l: sf^of
  - 3 e: zf
  - 4 ne: ~zf
  - 5 ge: ~(sf^of)
  - 6 g: ~(sf^of)&~zf
  - 7-15: 0
- Wrap-around: ADD/SUB overflow wraps silently and is reported only via cf/of.
- Shift amounts use a[5:0] only; shift by 0 returns b.
- Simultaneous reset and clock edge: reset wins.

Test Plan:
- Reset: hold rst_n=0 with random inputs and clocks -> all outputs 0; cond_fn=0 gives cond_true=1, cond_fn=3 gives cond_true=0.
- ADD overflow: a=1, b=0x7FFF_FFFF_FFFF_FFFF, sel=0, set_cc=1 -> alu_out=0x8000_0000_0000_0000, sf=1, of=1, cf=0, zf=0; cond_fn=2 (l) gives 0.
- SUB equal and borrow:
  - a=5, b=5, sel=1, set_cc=1 -> alu_out=0, zf=1, cf=0; cond_fn=3 gives 1.
  - Then a=6, b=5 -> alu_out=0xFFFF_FFFF_FFFF_FFFF, cf=1, sf=1, of=0; cond_fn=2 gives 1.
- Stack adjust with flags held: after the SUB, a=-8 (0xFFFF_FFFF_FFFF_FFF8), b=0x100, sel=0, set_cc=0 -> alu_out=0xF8; flags unchanged (cf=1, sf=1).
- Logic and shift:
  - a=0xF0, b=0xFF, sel=3, set_cc=1 -> alu_out=0x0F, cf=0, of=0, zf=0, sf=0.
  - sel=9, a=4, b=0x8000_0000_0000_0000 -> alu_out=0xF800_0000_0000_0000.
- Async reset mid-operation: after a nonzero result, pulse rst_n low between edges -> outputs clear immediately without a clock edge; first edge after release loads new result.
